uart_tx_arbiter: RTL and testbench

- Shares one byte-wide UART transmitter between NUM_SRC requesters, each presenting a 16-bit result word (FIR outputs, counters, status).
- Round-robin arbitration selects one requester; the word is captured and sent as a framed packet: header byte, LSB, MSB, plus an optional checksum byte.
- Sits between the datapath producers and the UART TX core; sequences the TX core through its TxD_start/TxD_busy handshake.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one byte-wide UART TX core among NUM_SRC 16-bit producers.
// Frame = {HDR_TAG,src}, LSB, MSB; define CHECKSUM_EN to append an XOR checksum byte.
module uart_tx_arbiter #(
  parameter int         NUM_SRC       = 4,
  parameter logic [4:0] HDR_TAG       = 5'b10100,
  parameter int         START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [16*NUM_SRC-1:0]  data_in,
  output logic [NUM_SRC-1:0]     ack,
  input  logic                   TxD_busy,
  output logic                   TxD_start,
  output logic [7:0]             TxD_data,
  output logic                   arb_busy,
  output logic [2:0]             last_src,
  output logic                   timeout_err
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
`ifdef CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;

  state_t        state;
  logic [2:0]    ptr, grant, win;
  logic [3:0]    cand;
  logic          found;
  logic [15:0]   word_r;
  logic [1:0]    byte_idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    req_x, hdr, tx_byte;
  logic [127:0]  data_x;

  // widen to the 8-source maximum so source indices are always 3 bits
  assign req_x  = 8'(req);
  assign data_x = 128'(data_in);
  assign hdr    = {HDR_TAG, grant};

  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
      if (!found && req_x[cand[2:0]]) begin
        win   = cand[2:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    tx_byte = hdr;
      2'd1:    tx_byte = word_r[7:0];
      2'd2:    tx_byte = word_r[15:8];
`ifdef CHECKSUM_EN
      default: tx_byte = hdr ^ word_r[7:0] ^ word_r[15:8];
`else
      default: tx_byte = 8'h00;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'(NUM_SRC - 1);
      grant       <= '0;
      word_r      <= '0;
      byte_idx    <= '0;
      tmo_cnt     <= '0;
      ack         <= '0;
      TxD_start   <= 1'b0;
      TxD_data    <= '0;
      arb_busy    <= 1'b0;
      last_src    <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack       <= '0;
      TxD_start <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          grant <= win;
          state <= LOAD;
        end
        LOAD: begin
          word_r   <= data_x[{grant, 4'b0000} +: 16];
          ack      <= NUM_SRC'(1) << grant;
          last_src <= grant;
          ptr      <= grant;
          arb_busy <= 1'b1;
          byte_idx <= '0;
          state    <= START;
        end
        START: if (!TxD_busy) begin
          TxD_start <= 1'b1;
          TxD_data  <= tx_byte;
          tmo_cnt   <= '0;
          state     <= WAIT_HI;
        end
        // a core that never raises busy is assumed to have taken the byte
        WAIT_HI: begin
          if (TxD_busy) state <= WAIT_LO;
          else if (tmo_cnt == TW'(START_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= WAIT_LO;
          end else tmo_cnt <= tmo_cnt + TW'(1);
        end
        WAIT_LO: if (!TxD_busy) begin
          if (byte_idx == LAST_IDX) begin
            arb_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            byte_idx <= byte_idx + 2'd1;
            state    <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes/grants queued at stimulus, checked at TxD_start/ack.
module tb_uart_tx_arbiter;
  localparam int NS = 4;
`ifdef CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic              clk = 1'b0, rst = 1'b1;
  logic [NS-1:0]     req = '0;
  logic [16*NS-1:0]  data_in = '0;
  logic [NS-1:0]     ack;
  logic              TxD_busy, TxD_start, arb_busy, timeout_err;
  logic [7:0]        TxD_data;
  logic [2:0]        last_src;
  logic              model_busy = 1'b0, hold_busy = 1'b0, tx_en = 1'b1;
  int                total = 0, bad = 0, starts = 0, acks = 0;
  int                base, abase, nstart;
  logic [7:0]        sb_byte[$];
  int                sb_ack[$];

  assign TxD_busy = model_busy | hold_busy;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_SRC(NS), .HDR_TAG(5'b10100), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .TxD_busy(TxD_busy), .TxD_start(TxD_start), .TxD_data(TxD_data),
    .arb_busy(arb_busy), .last_src(last_src), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int src, input logic [15:0] w);
    logic [7:0] h;
    h = {5'b10100, 3'(src)};
    sb_ack.push_back(src);
    sb_byte.push_back(h);
    sb_byte.push_back(w[7:0]);
    sb_byte.push_back(w[15:8]);
`ifdef CHECKSUM_EN
    sb_byte.push_back(h ^ w[7:0] ^ w[15:8]);
`endif
  endtask

  // TX core model: busy for 10 cycles after a sampled start pulse
  initial forever begin
    @(posedge clk);
    if (tx_en && TxD_start) begin
      #1 model_busy = 1'b1;
      repeat (10) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  initial forever begin
    int e;
    @(negedge clk);
    if (!rst && TxD_start) begin
      starts++;
      if (sb_byte.size() == 0) chk("extra_byte", 32'(TxD_start), 32'd0);
      else chk("byte", 32'(TxD_data), 32'(sb_byte.pop_front()));
    end
    if (!rst && |ack) begin
      acks++;
      chk("ack_1hot", 32'($countones(ack)), 32'd1);
      if (sb_ack.size() == 0) chk("extra_ack", 32'(|ack), 32'd0);
      else begin
        e = sb_ack.pop_front();
        chk("ack_src", 32'(ack), 32'(NS'(1) << e));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    sb_byte.delete();
    sb_ack.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int idx);
    int n = 0;
    while (!ack[idx] && n < 300) begin @(negedge clk); n++; end
    chk("ack_wait", 32'(ack[idx]), 32'd1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!TxD_start && n < 100) begin @(negedge clk); n++; end
    chk("start_wait", 32'(TxD_start), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (arb_busy && n < bound) begin @(negedge clk); n++; end
    chk("idle_wait", 32'(arb_busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_start", 32'(TxD_start), 0);
    chk("rst_data", 32'(TxD_data), 0);
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_last", 32'(last_src), 0);
    chk("rst_tmo", 32'(timeout_err), 0);

    // single source, latency and byte order
    data_in[15:0] = 16'h1234;
    push_frame(0, 16'h1234);
    base = starts;
    req = 4'b0001;
    @(negedge clk); chk("ack_early", 32'(ack), 0);
    @(negedge clk); chk("ack_lat", 32'(ack), 32'h1); req = '0;
    @(negedge clk); chk("start_lat", 32'(TxD_start), 1);
    wait_idle(400);
    chk("t1_nbytes", 32'(starts - base), 32'(NB));
    chk("t1_tx_idle", 32'(TxD_busy), 0);
    chk("t1_sb", 32'(sb_byte.size()), 0);

    // all requesting: rotation 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      data_in[16*i +: 16] = 16'(i << 4);
      push_frame(i, 16'(i << 4));
    end
    base = starts; abase = acks;
    req = 4'b1111;
    wait_ack(3);
    req = '0;
    wait_idle(400);
    chk("t2_acks", 32'(acks - abase), 32'd4);
    chk("t2_nbytes", 32'(starts - base), 32'(4 * NB));
    chk("t2_sb", 32'(sb_byte.size() + sb_ack.size()), 0);
    chk("t2_last", 32'(last_src), 3);
    chk("t2_no_tmo", 32'(timeout_err), 0);

    // TX core never goes busy
    do_reset();
    tx_en = 1'b0;
    data_in[15:0] = 16'h5678;
    push_frame(0, 16'h5678);
    base = starts;
    req = 4'b0001; wait_ack(0); req = '0;
    wait_start();
    repeat (15) @(negedge clk);
    chk("tmo_before", 32'(timeout_err), 0);
    @(negedge clk);
    chk("tmo_set", 32'(timeout_err), 1);
    wait_idle(400);
    chk("t3_nbytes", 32'(starts - base), 32'(NB));
    chk("t3_sticky", 32'(timeout_err), 1);
    tx_en = 1'b1;

    // busy already high in START
    do_reset();
    hold_busy = 1'b1;
    data_in[15:0] = 16'h9abc;
    push_frame(0, 16'h9abc);
    base = starts;
    req = 4'b0001; wait_ack(0); req = '0;
    nstart = 0;
    repeat (6) begin @(negedge clk); if (TxD_start) nstart++; end
    chk("hold_nostart", 32'(nstart), 0);
    hold_busy = 1'b0;
    @(negedge clk);
    chk("hold_release", 32'(TxD_start), 1);
    wait_idle(400);
    chk("t4_nbytes", 32'(starts - base), 32'(NB));

    // reset during WAIT_LO of byte 1
    do_reset();
    data_in[47:32] = 16'hbeef;
    push_frame(2, 16'hbeef);
    req = 4'b0100; wait_ack(2); req = '0;
    wait_start();
    @(negedge clk);
    wait_start();
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(arb_busy), 1);
    rst = 1'b1;
    sb_byte.delete();
    @(negedge clk);
    chk("r5_ack", 32'(ack), 0);
    chk("r5_start", 32'(TxD_start), 0);
    chk("r5_data", 32'(TxD_data), 0);
    chk("r5_busy", 32'(arb_busy), 0);
    chk("r5_last", 32'(last_src), 0);
    chk("r5_tmo", 32'(timeout_err), 0);
    rst = 1'b0;
    data_in[15:0]  = 16'h0f0f;
    data_in[63:48] = 16'h3c3c;
    push_frame(0, 16'h0f0f);
    push_frame(3, 16'h3c3c);
    req = 4'b1001;
    wait_ack(0); req[0] = 1'b0;
    wait_ack(3); req[3] = 1'b0;
    wait_idle(400);
    chk("t5_sb", 32'(sb_byte.size() + sb_ack.size()), 0);
    chk("t5_last", 32'(last_src), 3);

    // granted source drops, another requests mid-frame
    do_reset();
    data_in[47:32] = 16'h2222;
    data_in[31:16] = 16'h1111;
    push_frame(2, 16'h2222);
    base = starts;
    req = 4'b0100; wait_ack(2); req = '0;
    @(negedge clk);
    req = 4'b0010;
    push_frame(1, 16'h1111);
    wait_ack(1);
    chk("t6_gap", 32'(starts - base), 32'(NB));
    req = '0;
    wait_idle(400);
    chk("t6_sb", 32'(sb_byte.size() + sb_ack.size()), 0);
    chk("t6_last", 32'(last_src), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
